// File: rtl/ex_issue_stage.sv
// Execute-issue pipeline register: holds one decoded instruction, forwards
// MEM/WB results into its operands and presents ALU inputs downstream.
module ex_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [4:0]            rs1_addr_i,
  input  logic [4:0]            rs2_addr_i,
  input  logic [4:0]            rd_addr_i,
  input  logic [3:0]            alu_ctrl_i,
  input  logic                  op1_sel_i,
  input  logic                  op2_sel_i,
  input  logic                  reg_write_i,
  input  logic                  flush_i,
  input  logic                  out_ready_i,
  input  logic                  mem_reg_write_i,
  input  logic [4:0]            mem_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_result_i,
  input  logic                  wb_reg_write_i,
  input  logic [4:0]            wb_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  output logic                  out_valid_o,
  output logic [3:0]            ALUCtrl_o,
  output logic [DATA_WIDTH-1:0] ALUop1_o,
  output logic [DATA_WIDTH-1:0] ALUop2_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [4:0]            rd_addr_o,
  output logic                  reg_write_o
);

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]            rs1a_q, rs1a_d, rs2a_q, rs2a_d, rda_q, rda_d;
  logic [3:0]            alu_q, alu_d;
  logic                  s1_q, s1_d, s2_q, s2_d, rw_q, rw_d;
  logic                  load;
  logic                  wb_hit1, wb_hit2;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;

  assign in_ready_o = flush_i | ~vld_q | out_ready_i;
  assign load       = in_valid_i & in_ready_o & ~flush_i;

  assign wb_hit1 = wb_reg_write_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs1a_q);
  assign wb_hit2 = wb_reg_write_i && (wb_rd_addr_i != 5'd0) && (wb_rd_addr_i == rs2a_q);

  always_comb begin
    vld_d  = vld_q;
    pc_d   = pc_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    imm_d  = imm_q;
    rs1a_d = rs1a_q;
    rs2a_d = rs2a_q;
    rda_d  = rda_q;
    alu_d  = alu_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    rw_d   = rw_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d  = 1'b1;
      pc_d   = pc_i;
      rs1_d  = rs1_data_i;
      rs2_d  = rs2_data_i;
      imm_d  = imm_i;
      rs1a_d = rs1_addr_i;
      rs2a_d = rs2_addr_i;
      rda_d  = rd_addr_i;
      alu_d  = alu_ctrl_i;
      s1_d   = op1_sel_i;
      s2_d   = op2_sel_i;
      rw_d   = reg_write_i;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end else if (vld_q) begin
      // Stalled: absorb WB writes now, since WB will have retired before we issue.
      if (wb_hit1) rs1_d = wb_result_i;
      if (wb_hit2) rs2_d = wb_result_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      rs1a_q <= '0;
      rs2a_q <= '0;
      rda_q  <= '0;
      alu_q  <= '0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rw_q   <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      pc_q   <= pc_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      imm_q  <= imm_d;
      rs1a_q <= rs1a_d;
      rs2a_q <= rs2a_d;
      rda_q  <= rda_d;
      alu_q  <= alu_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rw_q   <= rw_d;
    end
  end

  // MEM is younger than WB, so it wins; x0 never forwards.
  always_comb begin
    if (mem_reg_write_i && (mem_rd_addr_i != 5'd0) && (mem_rd_addr_i == rs1a_q)) fwd1 = mem_result_i;
    else if (wb_hit1) fwd1 = wb_result_i;
    else              fwd1 = rs1_q;
    if (mem_reg_write_i && (mem_rd_addr_i != 5'd0) && (mem_rd_addr_i == rs2a_q)) fwd2 = mem_result_i;
    else if (wb_hit2) fwd2 = wb_result_i;
    else              fwd2 = rs2_q;
  end

  assign out_valid_o  = vld_q;
  assign ALUCtrl_o    = alu_q;
  assign rd_addr_o    = rda_q;
  assign reg_write_o  = rw_q & vld_q;
  assign ALUop1_o     = s1_q ? pc_q : fwd1;
  assign ALUop2_o     = s2_q ? imm_q : fwd2;
  assign store_data_o = fwd2;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the held instruction.
module tb_ex_issue_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          in_valid_i, in_ready_o;
  logic [DW-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]    rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]    alu_ctrl_i;
  logic          op1_sel_i, op2_sel_i, reg_write_i, flush_i, out_ready_i;
  logic          mem_reg_write_i, wb_reg_write_i;
  logic [4:0]    mem_rd_addr_i, wb_rd_addr_i;
  logic [DW-1:0] mem_result_i, wb_result_i;
  logic          out_valid_o, reg_write_o;
  logic [3:0]    ALUCtrl_o;
  logic [DW-1:0] ALUop1_o, ALUop2_o, store_data_o;
  logic [4:0]    rd_addr_o;

  ex_issue_stage #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_ctrl_i(alu_ctrl_i), .op1_sel_i(op1_sel_i), .op2_sel_i(op2_sel_i),
    .reg_write_i(reg_write_i), .flush_i(flush_i), .out_ready_i(out_ready_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_result_i(wb_result_i),
    .out_valid_o(out_valid_o), .ALUCtrl_o(ALUCtrl_o), .ALUop1_o(ALUop1_o), .ALUop2_o(ALUop2_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc, rs1, rs2, imm;
    logic [4:0]    a1, a2, rd;
    logic [3:0]    alu;
    logic          s1, s2, rw;
  } instr_t;

  instr_t m_ins;
  bit     m_vld;
  bit     m_known;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [4:0] a, input logic [DW-1:0] held);
    if (a == 0) return held;
    if (mem_reg_write_i && mem_rd_addr_i == a) return mem_result_i;
    if (wb_reg_write_i && wb_rd_addr_i == a) return wb_result_i;
    return held;
  endfunction

  task automatic model_reset();
    m_ins   = '{pc: '0, rs1: '0, rs2: '0, imm: '0, a1: '0, a2: '0, rd: '0, alu: '0, s1: 1'b0, s2: 1'b0, rw: 1'b0};
    m_vld   = 1'b0;
    m_known = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready_o),  32'(flush_i | !m_vld | out_ready_i));
    chk({tag, ".out_valid"}, 32'(out_valid_o), 32'(m_vld));
    chk({tag, ".reg_write"}, 32'(reg_write_o), 32'(m_vld & m_ins.rw));
    if (m_known) begin
      chk({tag, ".alu"},   32'(ALUCtrl_o), 32'(m_ins.alu));
      chk({tag, ".rd"},    32'(rd_addr_o), 32'(m_ins.rd));
      chk({tag, ".op1"},   ALUop1_o, m_ins.s1 ? m_ins.pc : fwd(m_ins.a1, m_ins.rs1));
      chk({tag, ".op2"},   ALUop2_o, m_ins.s2 ? m_ins.imm : fwd(m_ins.a2, m_ins.rs2));
      chk({tag, ".store"}, store_data_o, fwd(m_ins.a2, m_ins.rs2));
    end
  endtask

  // One clock: snapshot inputs, let the edge happen, advance the model.
  task automatic tick();
    instr_t in;
    bit ld, fl, ordy, inv, wbw;
    logic [4:0] wba;
    logic [DW-1:0] wbr;
    in = '{pc: pc_i, rs1: rs1_data_i, rs2: rs2_data_i, imm: imm_i, a1: rs1_addr_i, a2: rs2_addr_i,
           rd: rd_addr_i, alu: alu_ctrl_i, s1: op1_sel_i, s2: op2_sel_i, rw: reg_write_i};
    fl = flush_i; ordy = out_ready_i; inv = in_valid_i;
    wbw = wb_reg_write_i; wba = wb_rd_addr_i; wbr = wb_result_i;
    ld = inv && !fl && (!m_vld || ordy);
    @(posedge clk);
    if (!rst_ni) model_reset();
    else if (fl) begin
      m_vld = 1'b0;
      m_known = 1'b0;
    end else if (ld) begin
      m_ins = in;
      m_vld = 1'b1;
      m_known = 1'b1;
    end else if (ordy) m_vld = 1'b0;
    else if (m_vld && wbw && wba != 0) begin
      if (wba == m_ins.a1) m_ins.rs1 = wbr;
      if (wba == m_ins.a2) m_ins.rs2 = wbr;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; alu_ctrl_i = '0;
    op1_sel_i = 0; op2_sel_i = 0; reg_write_i = 0; flush_i = 0; out_ready_i = 0;
    mem_reg_write_i = 0; mem_rd_addr_i = '0; mem_result_i = '0;
    wb_reg_write_i = 0; wb_rd_addr_i = '0; wb_result_i = '0;
  endtask

  task automatic load_instr(input logic [4:0] a1, input logic [DW-1:0] v1, input logic [4:0] a2,
                            input logic [DW-1:0] v2, input logic [3:0] alu);
    idle_inputs();
    in_valid_i = 1; rs1_addr_i = a1; rs1_data_i = v1; rs2_addr_i = a2; rs2_data_i = v2;
    alu_ctrl_i = alu; rd_addr_i = 5'd4; reg_write_i = 1; pc_i = 32'h100; imm_i = 32'h8;
    out_ready_i = 1;
    #2 tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_ni = 0;
    #2 check_all("reset");
    chk("reset.op1", ALUop1_o, 32'h0);
    #20 rst_ni = 1;
    @(posedge clk); #1;
    check_all("post_reset");
    chk("post_reset.in_ready", 32'(in_ready_o), 32'h1);

    // Basic load
    load_instr(5'd1, 32'd5, 5'd2, 32'd7, 4'b0000);
    out_ready_i = 1;
    #2 check_all("basic");
    chk("basic.op1", ALUop1_o, 32'd5);
    chk("basic.op2", ALUop2_o, 32'd7);
    chk("basic.valid", 32'(out_valid_o), 32'h1);
    tick();
    #2 chk("basic.drain", 32'(out_valid_o), 32'h0);

    // Forward priority
    load_instr(5'd3, 32'h1, 5'd5, 32'h2, 4'b0000);
    mem_reg_write_i = 1; mem_rd_addr_i = 5'd3; mem_result_i = 32'hAAAA0000;
    wb_reg_write_i = 1; wb_rd_addr_i = 5'd3; wb_result_i = 32'h11;
    #2 chk("fwd.mem", ALUop1_o, 32'hAAAA0000);
    check_all("fwd.mem");
    mem_reg_write_i = 0;
    #1 chk("fwd.wb", ALUop1_o, 32'h11);
    check_all("fwd.wb");
    out_ready_i = 1; wb_reg_write_i = 0;
    tick();

    // x0 never forwards
    load_instr(5'd6, 32'h3, 5'd0, 32'h0, 4'b0000);
    mem_reg_write_i = 1; mem_rd_addr_i = 5'd0; mem_result_i = 32'hFFFFFFFF;
    wb_reg_write_i = 1; wb_rd_addr_i = 5'd0; wb_result_i = 32'hFFFFFFFF;
    #2 chk("x0.op2", ALUop2_o, 32'h0);
    chk("x0.store", store_data_o, 32'h0);
    check_all("x0");
    idle_inputs(); out_ready_i = 1;
    tick();

    // Stall refresh
    load_instr(5'd9, 32'h1, 5'd10, 32'h2, 4'b0001);
    wb_reg_write_i = 1; wb_rd_addr_i = 5'd9; wb_result_i = 32'h42;
    #2 check_all("stall.wb");
    tick();
    idle_inputs();
    in_valid_i = 1; rd_addr_i = 5'd17; rs1_addr_i = 5'd9; rs1_data_i = 32'h99;
    #2 chk("stall.op1", ALUop1_o, 32'h42);
    chk("stall.in_ready", 32'(in_ready_o), 32'h0);
    check_all("stall.hold1");
    tick();
    #2 chk("stall.op1_later", ALUop1_o, 32'h42);
    chk("stall.rd_kept", 32'(rd_addr_o), 32'd4);
    check_all("stall.hold2");

    // Flush during back-to-back
    out_ready_i = 1; flush_i = 1; in_valid_i = 1; rd_addr_i = 5'd20;
    #1 tick();
    idle_inputs();
    #2 chk("flush.valid", 32'(out_valid_o), 32'h0);
    chk("flush.reg_write", 32'(reg_write_o), 32'h0);
    check_all("flush");
    tick();
    #2 chk("flush.dropped", 32'(out_valid_o), 32'h0);

    // Asynchronous reset while holding SUB
    load_instr(5'd1, 32'h5, 5'd2, 32'h3, 4'b0001);
    #1 chk("areset.pre_alu", 32'(ALUCtrl_o), 32'h1);
    rst_ni = 0;
    #1 chk("areset.valid", 32'(out_valid_o), 32'h0);
    chk("areset.alu", 32'(ALUCtrl_o), 32'h0);
    model_reset();
    check_all("areset");
    tick();
    rst_ni = 1;
    #2 check_all("areset.release");
    chk("areset.in_ready", 32'(in_ready_o), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid_i      = ($urandom_range(0, 99) < 60);
      pc_i            = $urandom; rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
      rs1_addr_i      = 5'($urandom_range(0, 3));
      rs2_addr_i      = 5'($urandom_range(0, 3));
      rd_addr_i       = 5'($urandom_range(0, 31));
      alu_ctrl_i      = 4'($urandom_range(0, 9));
      op1_sel_i       = 1'($urandom_range(0, 1));
      op2_sel_i       = 1'($urandom_range(0, 1));
      reg_write_i     = 1'($urandom_range(0, 1));
      flush_i         = ($urandom_range(0, 99) < 8);
      out_ready_i     = ($urandom_range(0, 99) < 50);
      mem_reg_write_i = 1'($urandom_range(0, 1));
      mem_rd_addr_i   = 5'($urandom_range(0, 3));
      mem_result_i    = $urandom;
      wb_reg_write_i  = 1'($urandom_range(0, 1));
      wb_rd_addr_i    = 5'($urandom_range(0, 3));
      wb_result_i     = $urandom;
      #2 check_all("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the datapath width for operands, immediates, PC and results.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk_i, in, 1, the single clock.
- rst_ni, in, 1, reset, asynchronous and active-low.
- in_valid_i, in, 1, a decoded instruction is presented.
- in_ready_o, out, 1, the stage accepts the instruction this cycle.
- pc_i, rs1_data_i, rs2_data_i, imm_i, in, DATA_WIDTH each: PC, register-file reads, immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i, in, 5 each: source and destination register numbers.
- alu_ctrl_i, in, 4: ALU operation code (0000 ADD ... 1001 SLTU).
- op1_sel_i, in, 1: operand 1 select, 0 = rs1, 1 = PC.
- op2_sel_i, in, 1: operand 2 select, 0 = rs2, 1 = immediate.
- reg_write_i, in, 1: the instruction writes rd.
- flush_i, in, 1: kill the held instruction and any input this cycle.
- out_ready_i, in, 1: downstream accepts the held instruction.
- mem_reg_write_i, in, 1; mem_rd_addr_i, in, 5; mem_result_i, in, DATA_WIDTH: MEM-stage forward source.
- wb_reg_write_i, in, 1; wb_rd_addr_i, in, 5; wb_result_i, in, DATA_WIDTH: WB-stage forward source.
- out_valid_o, out, 1: the held instruction is valid.
- ALUCtrl_o, out, 4: ALU control for the held instruction.
- ALUop1_o, ALUop2_o, out, DATA_WIDTH each: ALU operands.
- store_data_o, out, DATA_WIDTH: forwarded rs2 value, for stores.
- rd_addr_o, out, 5; reg_write_o, out, 1: destination for the held instruction.

Function
REQ-003 in_ready_o SHALL equal flush_i OR NOT out_valid_o OR out_ready_i, combinationally.
REQ-004 A load SHALL occur when in_valid_i AND in_ready_o AND NOT flush_i.
- On a load, the stage captures all input fields on the rising edge.
- out_valid_o is 1 in the next cycle, giving a latency of 1 cycle.
REQ-005 When no load occurs and out_ready_i is 1, out_valid_o SHALL go to 0 on the next edge.
REQ-006 When no load occurs, out_valid_o is 1 and out_ready_i is 0, all held fields SHALL remain unchanged, except as stated in REQ-007.
REQ-007 Held-operand refresh: while holding without a load, if wb_reg_write_i is 1 and wb_rd_addr_i is nonzero and equals the held rs1 address (or rs2 address), the held rs1 value (or rs2 value) SHALL be replaced with wb_result_i.
- Both rs1 and rs2 refresh in the same cycle when both match.
REQ-008 flush_i SHALL have priority over a load and over holding.
- The next out_valid_o is 0.
- The input presented this cycle is discarded.
- Held data fields need not change.
REQ-009 The forwarded rs1 value SHALL be selected combinationally, in priority order:
- mem_result_i, if mem_reg_write_i is 1 and mem_rd_addr_i equals the held rs1 address and is nonzero.
- Otherwise wb_result_i, if wb_reg_write_i is 1 and wb_rd_addr_i equals the held rs1 address and is nonzero.
- Otherwise the held rs1 value.
- The forwarded rs2 value SHALL be selected the same way against the held rs2 address.
REQ-010 Forwarding SHALL never select a source when the register address is 0.
REQ-011 ALUop1_o SHALL equal the held PC if op1_sel is 1, otherwise the forwarded rs1 value.
REQ-012 ALUop2_o SHALL equal the held immediate if op2_sel is 1, otherwise the forwarded rs2 value.
REQ-013 store_data_o SHALL always equal the forwarded rs2 value, regardless of op2_sel.
REQ-014 ALUCtrl_o, rd_addr_o and reg_write_o SHALL be driven directly from registers.
REQ-015 reg_write_o SHALL be gated: it reads 0 whenever out_valid_o is 0.
REQ-016 A simultaneous load and drain (out_valid_o = 1, out_ready_i = 1, in_valid_i = 1) SHALL replace the held instruction with no bubble cycle.

Reset
REQ-017 While rst_ni is 0, regardless of the clock, every register SHALL be cleared.
- out_valid_o = 0.
- ALUCtrl_o = 0000.
- rd_addr_o = 0 and reg_write_o = 0.
- Held PC, rs1, rs2, immediate, addresses and select bits = 0.
- With no forward source active, ALUop1_o, ALUop2_o and store_data_o = 0.
REQ-018 A reset asserted mid-hold SHALL discard the held instruction.
REQ-019 After rst_ni rises, in_ready_o SHALL be 1 in the first cycle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic load: load rs1 = 5, rs2 = 7, ADD, op selects 0/0, out_ready_i = 1 -> next cycle out_valid_o = 1, ALUop1_o = 5, ALUop2_o = 7, ALUCtrl_o = 0000; following cycle out_valid_o = 0.
- Forward priority: held rs1 address = 3, MEM forwards x3 = 0xAAAA0000 and WB forwards x3 = 0x11 in the same cycle -> ALUop1_o = 0xAAAA0000; MEM deasserted -> ALUop1_o = 0x11.
- x0 forwarding: held rs2 address = 0, held value 0, MEM forwards rd 0 = 0xFFFFFFFF -> ALUop2_o = 0 and store_data_o = 0.
- Stall refresh: hold with out_ready_i = 0, held rs1 address = 9 (value 1), WB writes x9 = 0x42 for one cycle and then deasserts -> ALUop1_o stays 0x42 in later stall cycles; a new input is not accepted (in_ready_o = 0).
- Flush during back-to-back: out_valid_o = 1, in_valid_i = 1, flush_i = 1 -> next cycle out_valid_o = 0 and reg_write_o = 0; the input is dropped.
- Asynchronous reset: rst_ni falls mid-cycle while holding SUB -> out_valid_o = 0 and ALUCtrl_o = 0000 immediately, before the next clock edge.
